// File: rtl/priv_1_12_hpm_counters_pkg.sv
// Shared constants, types and the read-modify-write helper for the counter CSR block.
package priv_types_1_12_pkg;

  localparam logic [1:0]  PRIV_M             = 2'b11;

  localparam logic [11:0] MCYCLE_ADDR        = 12'hB00;
  localparam logic [11:0] MINSTRET_ADDR      = 12'hB02;
  localparam logic [11:0] MHPMCOUNTER_BASE   = 12'hB00;
  localparam logic [11:0] MHPMEVENT_BASE     = 12'h320;
  localparam logic [11:0] MCOUNTINHIBIT_ADDR = 12'h320;
  localparam logic [11:0] MCOUNTEREN_ADDR    = 12'h306;
  localparam logic [11:0] CYCLE_ADDR         = 12'hC00;
  localparam logic [11:0] CSR_H_OFFSET       = 12'h080;

  typedef logic [4:0] counter_idx_t;

  typedef enum logic [1:0] {
    CSR_NONE,
    CSR_WRITE,
    CSR_SET,
    CSR_CLEAR
  } csr_op_t;

  function automatic logic [31:0] csr_rmw(csr_op_t op, logic [31:0] old_val, logic [31:0] new_val);
    logic [31:0] res;
    case (op)
      CSR_WRITE: res = new_val;
      CSR_SET:   res = old_val | new_val;
      CSR_CLEAR: res = old_val & ~new_val;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/priv_1_12_hpm_counters_if.sv
// CSR broadcast bus between the main CSR file (master) and the counter block (slave).
interface priv_1_12_hpm_counters_if;
  logic [11:0] csr_addr;
  logic        csr_write;
  logic        csr_set;
  logic        csr_clear;
  logic [31:0] new_csr_val;
  logic [1:0]  curr_priv;
  logic [31:0] old_csr_val;
  logic        csr_hit;
  logic        invalid_csr;

  modport master (
    output csr_addr, csr_write, csr_set, csr_clear, new_csr_val, curr_priv,
    input  old_csr_val, csr_hit, invalid_csr
  );

  modport slave (
    input  csr_addr, csr_write, csr_set, csr_clear, new_csr_val, curr_priv,
    output old_csr_val, csr_hit, invalid_csr
  );
endinterface

// File: rtl/priv_1_12_hpm_counters_counter64.sv
// 64-bit event counter with half-word CSR writes; a write in the same cycle drops the increment.
module priv_1_12_counter64 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] cnt
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        cnt <= '0;
    else if (wr_lo) cnt <= {cnt[63:32], wdata};
    else if (wr_hi) cnt <= {wdata, cnt[31:0]};
    else if (inc_en) cnt <= cnt + 64'd1;
  end

endmodule

// File: rtl/priv_1_12_hpm_counters.sv
// mcycle/minstret/mhpmcounter block with mcountinhibit, mcounteren, mhpmevent and user aliases.
module priv_1_12_hpm_counters
  import priv_types_1_12_pkg::*;
#(
  parameter int NUM_HPM = 4,
  parameter int EVENT_W = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  priv_1_12_hpm_counters_if.slave bus,
  input  logic                    inst_ret,
  input  logic [EVENT_W-1:0]      event_in
);

  localparam int          NCNT        = NUM_HPM + 2;
  localparam int          NEVT        = (NUM_HPM == 0) ? 1 : NUM_HPM;
  localparam logic [63:0] HPM_BITS    = ((64'd1 << NUM_HPM) - 64'd1) << 3;
  localparam logic [31:0] CNT_MASK    = 32'h5 | HPM_BITS[31:0];
  localparam logic [11:0] MCYCLEH_ADDR = MCYCLE_ADDR + CSR_H_OFFSET;
  localparam logic [11:0] CYCLEH_ADDR  = CYCLE_ADDR + CSR_H_OFFSET;

  logic [63:0] cnt_q [NCNT];
  logic [31:0] evt_q [NEVT];
  logic [31:0] inhibit_q, counteren_q;

  // ---------------- decode ----------------
  counter_idx_t idx;
  logic not_time, is_mlo, is_mhi, is_ulo, is_uhi, is_evt, is_inh, is_en;
  logic m_space, u_space, access, hit, invalid;

  assign idx      = bus.csr_addr[4:0];
  assign not_time = (idx != 5'd1);
  assign is_mlo   = (bus.csr_addr[11:5] == MHPMCOUNTER_BASE[11:5]) && not_time;
  assign is_mhi   = (bus.csr_addr[11:5] == MCYCLEH_ADDR[11:5]) && not_time;
  assign is_ulo   = (bus.csr_addr[11:5] == CYCLE_ADDR[11:5]) && not_time;
  assign is_uhi   = (bus.csr_addr[11:5] == CYCLEH_ADDR[11:5]) && not_time;
  assign is_evt   = (bus.csr_addr[11:5] == MHPMEVENT_BASE[11:5]) && (idx >= 5'd3);
  assign is_inh   = (bus.csr_addr == MCOUNTINHIBIT_ADDR);
  assign is_en    = (bus.csr_addr == MCOUNTEREN_ADDR);

  assign m_space  = is_mlo | is_mhi | is_evt | is_inh | is_en;
  assign u_space  = is_ulo | is_uhi;
  assign hit      = m_space | u_space;
  assign access   = bus.csr_write | bus.csr_set | bus.csr_clear;

  // User aliases are never writable; reads below M need the matching mcounteren bit.
  assign invalid  = (m_space && bus.curr_priv != PRIV_M) ||
                    (u_space && (access || (bus.curr_priv != PRIV_M && !counteren_q[idx])));

  // ---------------- read path ----------------
  logic [63:0] cnt_sel;
  logic [31:0] evt_sel, rd_val;

  always_comb begin
    cnt_sel = '0;
    evt_sel = '0;
    if (idx == 5'd0)      cnt_sel = cnt_q[0];
    else if (idx == 5'd2) cnt_sel = cnt_q[1];
    for (int j = 0; j < NUM_HPM; j++) begin
      if (idx == counter_idx_t'(j + 3)) begin
        cnt_sel = cnt_q[j+2];
        evt_sel = evt_q[j];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (is_mlo || is_ulo)      rd_val = cnt_sel[31:0];
    else if (is_mhi || is_uhi) rd_val = cnt_sel[63:32];
    else if (is_inh)           rd_val = inhibit_q;
    else if (is_en)            rd_val = counteren_q;
    else if (is_evt)           rd_val = evt_sel;
  end

  assign bus.old_csr_val = hit ? rd_val : 32'd0;
  assign bus.csr_hit     = hit;
  assign bus.invalid_csr = hit && invalid;

  // ---------------- write path ----------------
  csr_op_t     op;
  logic [31:0] wval;
  logic        we;

  always_comb begin
    op = CSR_NONE;
    if (bus.csr_write)      op = CSR_WRITE;
    else if (bus.csr_set)   op = CSR_SET;
    else if (bus.csr_clear) op = CSR_CLEAR;
  end

  assign wval = csr_rmw(op, rd_val, bus.new_csr_val);
  assign we   = hit && access && !invalid;

  // CNT_MASK leaves bit1 (time) permanently zero in both registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inhibit_q   <= '0;
      counteren_q <= '0;
    end else if (we) begin
      if (is_inh) inhibit_q   <= wval & CNT_MASK;
      if (is_en)  counteren_q <= wval & CNT_MASK;
    end
  end

  for (genvar j = 0; j < NEVT; j++) begin : g_evt
    if (j < NUM_HPM) begin : g_impl
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) evt_q[j] <= '0;
        else if (we && is_evt && idx == counter_idx_t'(j + 3)) evt_q[j] <= wval;
      end
    end else begin : g_none
      assign evt_q[j] = '0;
    end
  end

  // ---------------- counters ----------------
  // Bit 0 of the padded vector stands for event select 0, which never fires;
  // selects above EVENT_W land on zero padding.
  logic [63:0] ev_pad;
  assign ev_pad = {{(63-EVENT_W){1'b0}}, event_in, 1'b0};

  for (genvar s = 0; s < NCNT; s++) begin : g_cnt
    localparam counter_idx_t SIDX = counter_idx_t'((s == 0) ? 0 : (s == 1) ? 2 : s + 1);
    logic inc;

    if (s == 0) begin : g_cyc
      assign inc = !inhibit_q[0];
    end else if (s == 1) begin : g_ret
      assign inc = inst_ret && !inhibit_q[2];
    end else begin : g_hpm
      logic [31:0] sel;
      assign sel = evt_q[s-2];
      assign inc = !inhibit_q[s+1] && (sel[31:6] == 26'd0) && ev_pad[sel[5:0]];
    end

    priv_1_12_counter64 u_cnt (
      .CLK    (CLK),
      .RST    (RST),
      .inc_en (inc),
      .wr_lo  (we && is_mlo && idx == SIDX),
      .wr_hi  (we && is_mhi && idx == SIDX),
      .wdata  (wval),
      .cnt    (cnt_q[s])
    );
  end

endmodule

// File: tb/tb_priv_1_12_hpm_counters.sv
// Directed + randomized checks of the counter CSR block against a behavioural model.
module tb_priv_1_12_hpm_counters;
  localparam int NUM_HPM = 4;
  localparam int EVENT_W = 8;

  logic CLK = 1'b0;
  logic RST;
  logic inst_ret;
  logic [EVENT_W-1:0] event_in;

  priv_1_12_hpm_counters_if bus ();

  priv_1_12_hpm_counters #(.NUM_HPM(NUM_HPM), .EVENT_W(EVENT_W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .inst_ret (inst_ret),
    .event_in (event_in)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // model state, indexed by CSR low-5-bit index
  longint unsigned mc [32];
  logic [31:0] mevt [32];
  logic [31:0] minh, men;
  logic [31:0] obs_rd;
  logic        obs_inv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit impl(input int n);
    return n == 0 || n == 2 || (n >= 3 && n < 3 + NUM_HPM);
  endfunction

  function automatic bit in_rng(input logic [11:0] a, input logic [11:0] lo, input logic [11:0] hi);
    return a >= lo && a <= hi;
  endfunction

  function automatic bit lo_rng(input logic [11:0] a);
    return (in_rng(a, 12'hB00, 12'hB1F) || in_rng(a, 12'hC00, 12'hC1F)) && a[4:0] != 5'd1;
  endfunction

  function automatic bit hi_rng(input logic [11:0] a);
    return (in_rng(a, 12'hB80, 12'hB9F) || in_rng(a, 12'hC80, 12'hC9F)) && a[4:0] != 5'd1;
  endfunction

  function automatic bit m_hit(input logic [11:0] a);
    return lo_rng(a) || hi_rng(a) || a == 12'h320 || a == 12'h306 || in_rng(a, 12'h323, 12'h33F);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int n = int'(a[4:0]);
    if (lo_rng(a)) return 32'(mc[n]);
    if (hi_rng(a)) return 32'(mc[n] >> 32);
    if (a == 12'h320) return minh;
    if (a == 12'h306) return men;
    if (in_rng(a, 12'h323, 12'h33F)) return mevt[n];
    return 32'd0;
  endfunction

  function automatic bit m_illegal(input logic [11:0] a, input bit acc, input logic [1:0] p);
    int n = int'(a[4:0]);
    if (!m_hit(a)) return 0;
    if ((a[11:8] == 4'hB || a[11:8] == 4'h3) && p != 2'b11) return 1;
    if (a[11:8] == 4'hC && (acc || (p != 2'b11 && !men[n]))) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] impl_mask();
    logic [31:0] m = '0;
    for (int n = 0; n < 32; n++) if (impl(n)) m[n] = 1'b1;
    return m;
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 32; n++) begin
      mc[n] = 0;
      mevt[n] = '0;
    end
    minh = '0;
    men  = '0;
  endtask

  task automatic m_update(input logic [11:0] a, input logic w, input logic s, input logic c,
                          input logic [31:0] v, input logic [1:0] p, input logic ir,
                          input logic [EVENT_W-1:0] ev);
    longint unsigned nxt [32];
    int n = int'(a[4:0]);
    logic [31:0] old = m_read(a);
    logic [31:0] wv;
    bit commit = m_hit(a) && (w || s || c) && !m_illegal(a, w || s || c, p);
    for (int k = 0; k < 32; k++) begin
      bit inc = 0;
      if (impl(k)) begin
        if (k == 0)      inc = !minh[0];
        else if (k == 2) inc = ir && !minh[2];
        else begin
          int sel = int'(mevt[k]);
          inc = !minh[k] && mevt[k] >= 1 && mevt[k] <= EVENT_W && ev[sel-1];
        end
      end
      nxt[k] = mc[k] + (inc ? 64'd1 : 64'd0);
    end
    wv = w ? v : s ? (old | v) : (old & ~v);
    if (commit) begin
      if (lo_rng(a) && impl(n))      nxt[n] = (mc[n] & 64'hFFFFFFFF_00000000) | longint'(wv);
      else if (hi_rng(a) && impl(n)) nxt[n] = (longint'(wv) << 32) | (mc[n] & 64'h00000000_FFFFFFFF);
      else if (a == 12'h320)         minh = wv & impl_mask();
      else if (a == 12'h306)         men  = wv & impl_mask();
      else if (impl(n))              mevt[n] = wv;
    end
    for (int k = 0; k < 32; k++) mc[k] = nxt[k];
  endtask

  // one bus cycle: drive after negedge, check mid-low phase, advance model on posedge
  task automatic step(input logic [11:0] a, input logic w, input logic s, input logic c,
                      input logic [31:0] v, input logic [1:0] p, input logic ir,
                      input logic [EVENT_W-1:0] ev);
    bit eh;
    bus.csr_addr = a; bus.csr_write = w; bus.csr_set = s; bus.csr_clear = c;
    bus.new_csr_val = v; bus.curr_priv = p; inst_ret = ir; event_in = ev;
    #2;
    eh = m_hit(a);
    obs_rd  = bus.old_csr_val;
    obs_inv = bus.invalid_csr;
    chk($sformatf("hit@%h", a), 32'(bus.csr_hit), 32'(eh));
    chk($sformatf("rd@%h", a), obs_rd, eh ? m_read(a) : 32'd0);
    chk($sformatf("inv@%h", a), 32'(obs_inv), 32'(m_illegal(a, w || s || c, p)));
    @(posedge CLK);
    m_update(a, w, s, c, v, p, ir, ev);
    @(negedge CLK);
  endtask

  task automatic rd(input logic [11:0] a, input logic [1:0] p);
    step(a, 0, 0, 0, 32'd0, p, 0, '0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    step(a, 1, 0, 0, v, 2'b11, 0, '0);
  endtask

  task automatic idle(input logic ir, input logic [EVENT_W-1:0] ev);
    step(12'h000, 0, 0, 0, 32'd0, 2'b11, ir, ev);
  endtask

  logic [11:0] pool [14] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB86, 12'hB10,
                             12'h320, 12'h323, 12'h326, 12'h306, 12'hC00, 12'hC83, 12'hC01};

  initial begin
    logic [31:0] v_pre;
    RST = 1'b1;
    bus.csr_addr = '0; bus.csr_write = 0; bus.csr_set = 0; bus.csr_clear = 0;
    bus.new_csr_val = '0; bus.curr_priv = 2'b11; inst_ret = 0; event_in = '0;
    m_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // reset state and free-running mcycle
    rd(12'hB00, 2'b11);
    chk("reset_mcycle", obs_rd, 32'd0);
    repeat (9) idle(0, '0);
    rd(12'hB00, 2'b11);
    chk("mcycle_10", obs_rd, 32'd10);
    rd(12'hB80, 2'b11);
    chk("mcycleh_0", obs_rd, 32'd0);

    // asynchronous reset mid-run
    bus.csr_addr = 12'hB00;
    #1 RST = 1'b1;
    #1 m_reset();
    chk("async_reset", bus.old_csr_val, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // lo-half wrap carries into hi
    wr(12'hB80, 32'd0);
    wr(12'hB00, 32'hFFFF_FFFF);
    idle(0, '0);
    rd(12'hB00, 2'b11);
    chk("wrap_lo", obs_rd, 32'd0);
    rd(12'hB80, 2'b11);
    chk("wrap_hi", obs_rd, 32'd1);

    // hpm3 selecting event 3 (event_in[2]), then inhibited
    wr(12'h323, 32'd3);
    repeat (5) idle(0, 8'b0000_0100);
    repeat (7) idle(0, 8'b0000_0001);
    rd(12'hB03, 2'b11);
    chk("hpm3_count", obs_rd, 32'd5);
    step(12'h320, 0, 1, 0, 32'h8, 2'b11, 0, '0);
    repeat (4) idle(0, 8'b0000_0100);
    rd(12'hB03, 2'b11);
    chk("hpm3_inhibit", obs_rd, 32'd5);
    wr(12'h320, 32'd0);

    // write beats the same-cycle retire
    step(12'hB02, 1, 0, 0, 32'h100, 2'b11, 1, '0);
    rd(12'hB02, 2'b11);
    chk("minstret_wr", obs_rd, 32'h100);
    idle(1, '0);
    rd(12'hB02, 2'b11);
    chk("minstret_inc", obs_rd, 32'h101);

    // user alias gating
    rd(12'hC00, 2'b00);
    chk("u_rd_gated", 32'(obs_inv), 32'd1);
    step(12'h306, 0, 1, 0, 32'd1, 2'b11, 0, '0);
    rd(12'hC00, 2'b00);
    chk("u_rd_ok", 32'(obs_inv), 32'd0);
    step(12'hC00, 1, 0, 0, 32'd5, 2'b00, 0, '0);
    v_pre = obs_rd;
    chk("u_wr_inv", 32'(obs_inv), 32'd1);
    rd(12'hB00, 2'b11);
    chk("u_wr_nochange", obs_rd, v_pre + 32'd1);

    // unimplemented counter and WARL mcounteren
    wr(12'hB10, 32'hDEAD);
    rd(12'hB10, 2'b11);
    chk("unimpl_rd", obs_rd, 32'd0);
    chk("unimpl_inv", 32'(obs_inv), 32'd0);
    wr(12'h306, 32'hFFFF_FFFF);
    rd(12'h306, 2'b11);
    chk("mcounteren_warl", obs_rd, 32'h0000_007D);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      logic [31:0] v;
      logic [1:0]  p;
      int op = int'($urandom_range(0, 5));
      a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 13)];
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 10);
        1:       v = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: v = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       p = 2'b00;
        1:       p = 2'b01;
        default: p = 2'b11;
      endcase
      step(a, op == 0, op == 1, op == 2, v, p, 1'($urandom), EVENT_W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
